// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit logic/arithmetic unit with valid/ready handshakes and status flags.
// Add/sub/logic results are ready one cycle after accept; multiply is a WIDTH-step shift-add.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an op
// MUL   | one shift-add step per cycle, r_cnt counts down to the last step
// DONE  | out_valid=1, result and flags held until out_ready
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             m,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_f;
  logic                 r_z;
  logic                 r_n;
  logic                 r_c;
  logic                 r_v;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]     w_res;
  logic                 w_c;
  logic                 w_v;

  // add-with-carry reuses the flag_c left by the previous completed op
  assign w_sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (s == 2'b11) & r_c};
  assign w_diff    = {1'b0, a} - {1'b0, b};
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    if (r_state == MUL) begin
      w_res = w_acc_nxt[WIDTH-1:0];
      w_c   = |w_acc_nxt[2*WIDTH-1:WIDTH];
    end else if (!m) begin
      case (s)
        2'b00:   w_res = a;
        2'b01:   w_res = ~a;
        2'b10:   w_res = a ^ b;
        default: w_res = ~(a ^ b);
      endcase
    end else begin
      case (s)
        2'b00, 2'b11: begin
          w_res = w_sum[WIDTH-1:0];
          w_c   = w_sum[WIDTH];
          w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        end
        2'b01: begin
          w_res = w_diff[WIDTH-1:0];
          w_c   = w_diff[WIDTH];
          w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
        end
        default: begin
          w_res = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (m && (s == 2'b10)) begin
              r_mcand  <= {{WIDTH{1'b0}}, a};
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= CW'(WIDTH - 1);
              r_state  <= MUL;
            end else begin
              r_f         <= w_res;
              r_z         <= (w_res == '0);
              r_n         <= w_res[WIDTH-1];
              r_c         <= w_c;
              r_v         <= w_v;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          // terminal count: this is the WIDTH-th step, so results load from w_acc_nxt
          if (r_cnt == '0) begin
            r_f         <= w_res;
            r_z         <= (w_res == '0);
            r_n         <= w_res[WIDTH-1];
            r_c         <= w_c;
            r_v         <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign f         = r_f;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_c    = r_c;
  assign flag_v    = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed and random ops, scoreboard queue fed at accept,
// monitor pops at each output transfer and compares against an arithmetic model.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         m;
  logic [1:0]   s;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .m(m), .s(s), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .f(f),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] f;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_c = 1'b0;
  int   last_wait = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint dut_word();
    return longint'({f, flag_z, flag_n, flag_c, flag_v});
  endfunction

  function automatic longint exp_word(input exp_t e);
    return longint'({e.f, e.z, e.n, e.c, e.v});
  endfunction

  // Signed-range overflow and modular arithmetic straight from the function table.
  function automatic exp_t model(input bit mm, input bit [1:0] ss,
                                 input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input bit cin);
    exp_t   e;
    longint md = longint'(1) << W;
    longint ua = longint'(aa);
    longint ub = longint'(bb);
    longint sa = (ua >= md / 2) ? ua - md : ua;
    longint sb = (ub >= md / 2) ? ub - md : ub;
    longint ci = (ss == 2'b11 && cin) ? 1 : 0;
    longint r;
    longint sr;
    e.c = 1'b0;
    e.v = 1'b0;
    if (!mm) begin
      case (ss)
        2'd0:    r = ua;
        2'd1:    r = (md - 1) - ua;
        2'd2:    r = ua ^ ub;
        default: r = (md - 1) - (ua ^ ub);
      endcase
    end else begin
      case (ss)
        2'd1: begin
          r   = ua - ub;
          e.c = (ua < ub);
          sr  = sa - sb;
          e.v = (sr >= md / 2) || (sr < -(md / 2));
        end
        2'd2: begin
          r   = ua * ub;
          e.c = (r >= md);
        end
        default: begin
          r   = ua + ub + ci;
          e.c = (r >= md);
          sr  = sa + sb + ci;
          e.v = (sr >= md / 2) || (sr < -(md / 2));
        end
      endcase
    end
    if (r < 0) r = r + md;
    r   = r % md;
    e.f = r[W-1:0];
    e.z = (r == 0);
    e.n = e.f[W-1];
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    #3;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got f=0x%0h with no op outstanding at %0t", f, $time);
      end else begin
        e = q.pop_front();
        chk("result", dut_word(), exp_word(e));
      end
    end
  end

  task automatic run_op(input bit mm, input bit [1:0] ss, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input int hold);
    exp_t e;
    int   wt;
    int   lat;
    bit   is_mul;
    @(negedge clk);
    out_ready = (hold == 0);
    m = mm; s = ss; a = aa; b = bb;
    in_valid = 1'b1;
    #1;
    wt = 0;
    while (!in_ready && wt < 50) begin
      @(negedge clk);
      #1;
      wt++;
    end
    last_wait = wt;
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e = model(mm, ss, aa, bb, model_c);
    model_c = e.c;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    is_mul = mm && (ss == 2'b10);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); m = 1'($urandom); s = 2'($urandom);
      #1;
      lat++;
      if (out_valid) break;
      chk("busy_in_ready", longint'(in_ready), 0);
    end
    chk("latency", lat, is_mul ? W + 1 : 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom);
      #1;
      chk("hold_result", dut_word(), exp_word(e));
      chk("hold_out_valid", longint'(out_valid), 1);
      chk("hold_in_ready", longint'(in_ready), 0);
    end
    if (hold > 0) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
    end
  endtask

  task automatic reset_mid_mul();
    @(negedge clk);
    out_ready = 1'b1;
    m = 1'b1; s = 2'b10; a = 8'hFF; b = 8'hFF;
    in_valid = 1'b1;
    #1;
    chk("mul_accept_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_cycle_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", longint'(in_ready), 1);
    chk("post_rst_out_valid", longint'(out_valid), 0);
    chk("post_rst_f_flags", dut_word(), 0);
    void'(q.pop_back());
    model_c = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      chk("no_valid_after_rst", longint'(out_valid), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    m = 1'b0; s = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_in_ready", longint'(in_ready), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_f_flags", dut_word(), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_cycle_in_ready", longint'(in_ready), 1);

    for (int k = 0; k < 4; k++) run_op(1'b0, 2'(k), 8'hC3, 8'h5A, 0);
    run_op(1'b1, 2'b00, 8'hF0, 8'h20, 0);
    run_op(1'b1, 2'b01, 8'h80, 8'h01, 0);
    run_op(1'b1, 2'b01, 8'h01, 8'h02, 0);
    run_op(1'b1, 2'b00, 8'hFF, 8'h01, 0);
    run_op(1'b1, 2'b11, 8'h00, 8'h00, 0);
    run_op(1'b1, 2'b10, 8'h0F, 8'h11, 0);
    run_op(1'b1, 2'b10, 8'h10, 8'h10, 0);

    run_op(1'b1, 2'b00, 8'h37, 8'h4C, 5);
    run_op(1'b0, 2'b10, 8'hA5, 8'h0F, 0);
    chk("post_backpressure_accept_wait", last_wait, 0);

    run_op(1'b1, 2'b00, 8'hFF, 8'h01, 0);
    reset_mid_mul();
    run_op(1'b1, 2'b11, 8'h01, 8'h01, 0);

    for (int k = 0; k < 40; k++)
      run_op(1'($urandom), 2'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 2));

    repeat (3) @(negedge clk);
    #4;
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
